hcsr04_echo_responder: RTL
==========================

Name: hcsr04_echo_responder

Overview:
- Sensor-side model of the ultrasonic ranging interface: accepts the controller's Trig pulse and returns an Echo pulse whose high time encodes a programmable distance, exactly as the physical module does.
- Used in the smartcar test harness and on-board loopback to exercise the obstacle controller without hardware.
- Also flags malformed triggers.

Parameters:
- CYC_PER_CM, 2900, clk cycles of Echo high per cm of distance (58 us/cm at 50 MHz)
- TRIG_MIN_CYC, 500, minimum synchronized Trig high time for a valid trigger (10 us)
- BURST_CYC, 10000, delay from trigger acceptance to Echo rise (200 us, emulated 40 kHz burst)
- TIMEOUT_CYC, 1900000, Echo high time for an out-of-range distance (38 ms)
- HOLDOFF_CYC, 500000, dead time after Echo falls before a new trigger is accepted (10 ms)
- MIN_CM, 2, smallest in-range distance
- MAX_CM, 400, largest in-range distance

Ports:
- clk, input, 1, system clock (50 MHz)
- rst_n, input, 1, asynchronous active-low reset
- trig, input, 1, Trig from the ranging controller; asynchronous, 2-FF synchronized internally
- distance_cm, input, 9, emulated obstacle distance in cm; sampled at trigger acceptance
- echo, output, 1, Echo pulse to the controller; registered
- busy, output, 1, high in any state other than IDLE or TRIG_HI
- meas_done, output, 1, one-cycle pulse on the cycle Echo falls
- trig_err, output, 1, one-cycle pulse when a Trig pulse shorter than TRIG_MIN_CYC ends

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - While rst_n is low: echo, busy, meas_done and trig_err are 0, state is IDLE, all counters and synchronizer flops are 0.
  - Reset asserted mid-Echo drops echo immediately, without waiting for a clock edge.
- trig passes through 2 flops to give trig_s. A registered copy trig_d gives the edges:
  - rise = trig_s & ~trig_d
  - fall = ~trig_s & trig_d
- State IDLE:
  - On rise: go to TRIG_HI with cnt = 1.
  - A trig_s already high on entry to IDLE (no rise) is ignored.
- State TRIG_HI:
  - While trig_s = 1: cnt increments, saturating at all-ones (24-bit cnt).
  - On fall with cnt >= TRIG_MIN_CYC: latch distance_cm into dist_q, compute echo_len, go to BURST with cnt = 0.
  - On fall with cnt < TRIG_MIN_CYC: pulse trig_err for one cycle and return to IDLE.
- echo_len rule:
  - If MIN_CM <= dist_q <= MAX_CM: echo_len = dist_q * CYC_PER_CM.
  - Otherwise (this includes 0): echo_len = TIMEOUT_CYC.
  - The product is 25 bits wide, is registered once on entry to BURST, and never overflows for 9-bit × 16-bit operands.
- State BURST:
  - Count BURST_CYC cycles, then go to ECHO and set echo = 1.
  - The first echo-high cycle is exactly BURST_CYC cycles after the TRIG_HI→BURST transition.
- State ECHO:
  - echo is held high for exactly echo_len cycles.
  - On the last cycle: clear echo, pulse meas_done in the cycle echo reads 0 for the first time, go to HOLDOFF.
- State HOLDOFF:
  - Count HOLDOFF_CYC cycles, then go to IDLE.
- Trig activity in BURST, ECHO or HOLDOFF is ignored: no trig_err, no restart.
  - A Trig pulse still high when HOLDOFF ends is not accepted, because a new rise is required.
- Changes to distance_cm after the latch do not affect the pulse in flight.
- Total latency from the trig pin falling to echo rising is BURST_CYC + 3 cycles (2 synchronizer flops plus 1 edge-detect flop).
- meas_done and trig_err are never high in the same cycle.
- busy is 1 exactly in BURST, ECHO and HOLDOFF.

Test Plan:
- Default parameters, distance_cm = 100, Trig high 600 cycles.
  - Expected: echo rises BURST_CYC+3 = 10003 cycles after the trig pin falls and stays high for exactly 290000 cycles.
  - Expected: meas_done pulses once and trig_err stays 0.
- Trig high 499 cycles (the synchronized width).
  - Expected: trig_err is one pulse, echo stays 0, busy stays 0, state returns to IDLE.
- distance_cm = 0, then distance_cm = 401, each with a valid Trig.
  - Expected: echo high for 1900000 cycles in each case.
  - With distance_cm = 2 the echo is high for 5800 cycles, and with 400 it is high for 1160000.
- Scaled parameters (CYC_PER_CM=4, BURST_CYC=8, HOLDOFF_CYC=20, TRIG_MIN_CYC=3), distance_cm = 10.
  - Drive a second Trig mid-Echo and a third during HOLDOFF.
  - Expected: echo is a single 40-cycle pulse and neither extra trigger starts a measurement.
  - Also change distance_cm to 50 during BURST. Expected: echo width is still 40.
- Scaled parameters, rst_n low in the middle of ECHO.
  - Expected: echo drops to 0 asynchronously and busy is 0.
  - After release, a valid Trig produces a normal pulse.
- Scaled parameters, Trig held high across the end of HOLDOFF.
  - Expected: no measurement starts.
  - Then drop Trig and raise it again for 5 cycles. Expected: exactly one Echo pulse.

Source files
------------

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor emulator: Trig in, Echo out whose high time encodes distance_cm.
// Latency: echo rises BURST_CYC+3 clk after the trig pin falls; triggers arriving while busy are ignored.
module hcsr04_echo_responder #(
  parameter int unsigned CYC_PER_CM   = 2900,
  parameter int unsigned TRIG_MIN_CYC = 500,
  parameter int unsigned BURST_CYC    = 10000,
  parameter int unsigned TIMEOUT_CYC  = 1900000,
  parameter int unsigned HOLDOFF_CYC  = 500000,
  parameter int unsigned MIN_CM       = 2,
  parameter int unsigned MAX_CM       = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       meas_done,
  output logic       trig_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam logic [23:0] CNT_MAX    = '1;
  localparam logic [23:0] TRIG_MIN   = 24'(TRIG_MIN_CYC);
  localparam logic [23:0] BURST_LAST = 24'(BURST_CYC - 1);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLDOFF_CYC - 1);
  localparam logic [15:0] CPC        = 16'(CYC_PER_CM);
  localparam logic [24:0] TIMEOUT    = 25'(TIMEOUT_CYC);
  localparam logic [8:0]  MIN_D      = 9'(MIN_CM);
  localparam logic [8:0]  MAX_D      = 9'(MAX_CM);

  state_t      state, state_nxt;
  logic        trig_m, trig_s, trig_d;
  logic        rise, fall;
  logic [23:0] cnt, cnt_nxt;
  logic [8:0]  dist_q, dist_nxt;
  logic [24:0] echo_len, echo_len_nxt;
  logic        echo_nxt, meas_done_nxt, trig_err_nxt;
  logic        in_range;

  assign rise     = trig_s & ~trig_d;
  assign fall     = ~trig_s & trig_d;
  assign in_range = (dist_q >= MIN_D) && (dist_q <= MAX_D);
  assign busy     = (state == BURST) || (state == ECHO) || (state == HOLDOFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_m    <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      dist_q    <= '0;
      echo_len  <= '0;
      echo      <= 1'b0;
      meas_done <= 1'b0;
      trig_err  <= 1'b0;
    end else begin
      trig_m    <= trig;
      trig_s    <= trig_m;
      trig_d    <= trig_s;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dist_q    <= dist_nxt;
      echo_len  <= echo_len_nxt;
      echo      <= echo_nxt;
      meas_done <= meas_done_nxt;
      trig_err  <= trig_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dist_nxt      = dist_q;
    echo_len_nxt  = echo_len;
    echo_nxt      = echo;
    meas_done_nxt = 1'b0;
    trig_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = TRIG_HI;
          cnt_nxt   = 24'd1;
        end
      end
      TRIG_HI: begin
        if (fall) begin
          cnt_nxt = '0;
          if (cnt >= TRIG_MIN) begin
            dist_nxt  = distance_cm;
            state_nxt = BURST;
          end else begin
            trig_err_nxt = 1'b1;
            state_nxt    = IDLE;
          end
        end else if (trig_s && (cnt != CNT_MAX)) begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      BURST: begin
        // dist_q is settled on the first BURST cycle; the product is registered here once
        if (cnt == '0) begin
          echo_len_nxt = in_range ? (25'(dist_q) * 25'(CPC)) : TIMEOUT;
        end
        if (cnt == BURST_LAST) begin
          state_nxt = ECHO;
          echo_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      ECHO: begin
        if ({1'b0, cnt} == (echo_len - 25'd1)) begin
          state_nxt     = HOLDOFF;
          echo_nxt      = 1'b0;
          meas_done_nxt = 1'b1;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        echo_nxt  = 1'b0;
      end
    endcase
  end

endmodule
